mem_stage_ls: RTL

Parametrised memory-access stage for the in-order pipeline, sitting between the EX and WB stages. It handles split-transaction data-SRAM responses: requests are issued in EX, and `data_ok`/`rdata` return here after a variable latency. Extracts and sign- or zero-extends byte/half/word(/double) load data, and buffers a returned datum while WB stalls. Supports a pipeline flush that discards in-flight loads without corrupting later ones.

---
 rtl/mem_pkg.sv | 23 ++
 rtl/mem_stage_ls_if.sv | 53 +++++
 rtl/mem_stage_ls_load_align.sv | 33 +++
 rtl/mem_stage_ls.sv | 146 ++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared types and defaults for the memory-access stage.
// Load-op encoding and datapath defaults.
package mem_pkg;

  localparam int DATA_W_DEFAULT   = 32;
  localparam int MAX_DROP_DEFAULT = 3;

  typedef enum logic [2:0] {
    MEM_LB   = 3'd0,
    MEM_LBU  = 3'd1,
    MEM_LH   = 3'd2,
    MEM_LHU  = 3'd3,
    MEM_LW   = 3'd4,
    MEM_LWU  = 3'd5,
    MEM_LD   = 3'd6,
    MEM_NONE = 3'd7
  } mem_op_e;

  function automatic int off_w(input int dw);
    return $clog2(dw / 8);
  endfunction

endpackage

// File: rtl/mem_stage_ls_if.sv
// EX/SRAM/WB bundle seen by the memory-access stage.
// master: surrounding pipeline; slave: the stage.
interface mem_stage_ls_if
  import mem_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEFAULT,
  parameter int PC_W      = 32,
  parameter int RF_ADDR_W = 5
) ();

  logic                 ws_allowin;
  logic                 ms_allowin;
  logic                 es_to_ms_valid;
  logic [PC_W-1:0]      es_pc;
  logic [DATA_W-1:0]    es_alu_result;
  logic                 es_mem_req;
  logic                 es_res_from_mem;
  mem_op_e              es_mem_op;
  logic                 es_rf_we;
  logic [RF_ADDR_W-1:0] es_rf_waddr;
  logic                 ms_flush;
  logic                 data_sram_data_ok;
  logic [DATA_W-1:0]    data_sram_rdata;
  logic                 ms_to_ws_valid;
  logic [PC_W-1:0]      ms_pc;
  logic                 ms_rf_we;
  logic [RF_ADDR_W-1:0] ms_rf_waddr;
  logic [DATA_W-1:0]    ms_rf_wdata;
  logic                 ms_fwd_ok;

  modport master (
    output ws_allowin, es_to_ms_valid, es_pc,
    output es_alu_result, es_mem_req,
    output es_res_from_mem, es_mem_op,
    output es_rf_we, es_rf_waddr, ms_flush,
    output data_sram_data_ok, data_sram_rdata,
    input  ms_allowin, ms_to_ws_valid, ms_pc,
    input  ms_rf_we, ms_rf_waddr, ms_rf_wdata,
    input  ms_fwd_ok
  );

  modport slave (
    input  ws_allowin, es_to_ms_valid, es_pc,
    input  es_alu_result, es_mem_req,
    input  es_res_from_mem, es_mem_op,
    input  es_rf_we, es_rf_waddr, ms_flush,
    input  data_sram_data_ok, data_sram_rdata,
    output ms_allowin, ms_to_ws_valid, ms_pc,
    output ms_rf_we, ms_rf_waddr, ms_rf_wdata,
    output ms_fwd_ok
  );

endinterface

// File: rtl/mem_stage_ls_load_align.sv
// load_align: byte-lane select and sign/zero extension.
// On a 32-bit datapath LWU and LD collapse to LW.
module load_align
  import mem_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEFAULT,
  parameter int OW     = off_w(DATA_W)
) (
  input  logic [DATA_W-1:0] raw,
  input  logic [OW-1:0]     off,
  input  mem_op_e           op,
  output logic [DATA_W-1:0] res
);

  logic [DATA_W-1:0] sh;

  assign sh = raw >> {off, 3'b000};

  always_comb begin
    res = raw;
    case (op)
      MEM_LB:  res = DATA_W'($signed(sh[7:0]));
      MEM_LBU: res = DATA_W'(sh[7:0]);
      MEM_LH:  res = DATA_W'($signed(sh[15:0]));
      MEM_LHU: res = DATA_W'(sh[15:0]);
      MEM_LW:  res = DATA_W'($signed(sh[31:0]));
      MEM_LWU: res = DATA_W'(sh[31:0]);
      MEM_LD:  res = sh;
      default: res = raw;
    endcase
  end

endmodule

// File: rtl/mem_stage_ls.sv
// mem_stage_ls: split-transaction load/store stage (EX -> WB).
// Optional MS_STALL_CNT_EN adds the ms_stall_cnt counter port.
module mem_stage_ls
  import mem_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEFAULT,
  parameter int PC_W      = 32,
  parameter int RF_ADDR_W = 5,
  parameter int MAX_DROP  = MAX_DROP_DEFAULT
) (
  input  logic        clk,
  input  logic        resetn,
`ifdef MS_STALL_CNT_EN
  output logic [31:0] ms_stall_cnt,
`endif
  mem_stage_ls_if.slave bus
);

  localparam int OW = off_w(DATA_W);
  localparam int DW = $clog2(MAX_DROP + 1);

  logic                 ms_valid;
  logic                 req_pend;
  logic                 buf_valid;
  logic [DW-1:0]        drop_cnt;
  logic [DW:0]          drop_nxt;
  logic [DATA_W-1:0]    buf_data;
  logic [DATA_W-1:0]    alu_q;
  logic [DATA_W-1:0]    raw;
  logic [DATA_W-1:0]    aligned;
  logic [PC_W-1:0]      pc_q;
  logic [RF_ADDR_W-1:0] waddr_q;
  logic                 we_q;
  logic                 from_mem_q;
  mem_op_e              op_q;

  logic data_ok_eff;
  logic ready_go;
  logic allowin;
  logic accept;
  logic go_out;
  logic buf_take;

  assign data_ok_eff = bus.data_sram_data_ok
                    && (drop_cnt == '0);
  assign ready_go = !req_pend || data_ok_eff
                 || buf_valid;
  // a new request must not race responses still owed to flushed loads
  assign allowin = (!ms_valid || (ready_go && bus.ws_allowin))
                && !((drop_cnt != '0) && bus.es_mem_req);
  assign accept = bus.es_to_ms_valid && allowin
               && !bus.ms_flush;
  assign go_out = ms_valid && ready_go && bus.ws_allowin;
  assign buf_take = data_ok_eff && ms_valid && req_pend
                 && !bus.ws_allowin;

  always_comb begin
    drop_nxt = {1'b0, drop_cnt};
    if (bus.ms_flush) begin
      drop_nxt = drop_nxt
        + (DW+1)'(ms_valid && req_pend && !data_ok_eff)
        + (DW+1)'(bus.es_to_ms_valid && allowin
                  && bus.es_mem_req);
    end
    if (bus.data_sram_data_ok && (drop_cnt != '0)) begin
      drop_nxt = drop_nxt - (DW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      drop_cnt <= '0;
    end else begin
      assert (drop_nxt <= (DW+1)'(MAX_DROP));
      drop_cnt <= (drop_nxt > (DW+1)'(MAX_DROP))
                ? DW'(MAX_DROP) : drop_nxt[DW-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      ms_valid   <= 1'b0;
      req_pend   <= 1'b0;
      buf_valid  <= 1'b0;
      buf_data   <= '0;
      alu_q      <= '0;
      pc_q       <= '0;
      waddr_q    <= '0;
      we_q       <= 1'b0;
      from_mem_q <= 1'b0;
      op_q       <= MEM_LB;
    end else if (bus.ms_flush) begin
      ms_valid  <= 1'b0;
      req_pend  <= 1'b0;
      buf_valid <= 1'b0;
    end else if (accept) begin
      ms_valid   <= 1'b1;
      req_pend   <= bus.es_mem_req;
      buf_valid  <= 1'b0;
      alu_q      <= bus.es_alu_result;
      pc_q       <= bus.es_pc;
      waddr_q    <= bus.es_rf_waddr;
      we_q       <= bus.es_rf_we;
      from_mem_q <= bus.es_res_from_mem;
      op_q       <= bus.es_mem_op;
    end else if (go_out || !ms_valid) begin
      ms_valid  <= 1'b0;
      req_pend  <= 1'b0;
      buf_valid <= 1'b0;
    end else if (buf_take) begin
      buf_data  <= bus.data_sram_rdata;
      buf_valid <= 1'b1;
      req_pend  <= 1'b0;
    end
  end

`ifdef MS_STALL_CNT_EN
  always_ff @(posedge clk) begin
    if (!resetn) begin
      ms_stall_cnt <= '0;
    end else if (ms_valid && req_pend && !buf_valid
                 && !data_ok_eff) begin
      ms_stall_cnt <= ms_stall_cnt + 32'd1;
    end
  end
`endif

  assign raw = buf_valid ? buf_data : bus.data_sram_rdata;

  load_align #(.DATA_W(DATA_W)) u_align (
    .raw (raw),
    .off (alu_q[OW-1:0]),
    .op  (op_q),
    .res (aligned)
  );

  assign bus.ms_allowin     = allowin;
  assign bus.ms_to_ws_valid = ms_valid && ready_go
                           && !bus.ms_flush;
  assign bus.ms_pc          = pc_q;
  assign bus.ms_rf_we       = ms_valid && we_q;
  assign bus.ms_rf_waddr    = waddr_q;
  assign bus.ms_rf_wdata    = from_mem_q ? aligned : alu_q;
  assign bus.ms_fwd_ok      = ms_valid && ready_go;

endmodule
